// File: rtl/onchip_memory_pipelined_pkg.sv
// Shared types and helpers for the pipelined on-chip memory slave.
//   mem_state_e      : sequencer state (zero-clear sweep, normal traffic)
//   READ_LATENCY_MAX : deepest supported read pipeline
//   clog2            : ceiling log2 used to size word indices
package onchip_mem_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } mem_state_e;

  localparam int unsigned READ_LATENCY_MAX = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    if (value > 1) begin
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
        result++;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/onchip_memory_pipelined_ram_core.sv
// Inferred single-port RAM with per-byte write enables.
//   clk        : clock
//   en         : clock enable for both the write and the read-address register
//   we         : write strobe (qualified by en)
//   addr       : word index
//   byteenable : per-byte write mask
//   wdata      : write data
//   q          : read data for the address captured at the last enabled edge
// The read address is registered and the array is read combinationally after
// it, so a write and a read-address capture on the same edge return the new
// word. Contents are never reset.
module onchip_ram_core
  import onchip_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 65536,
  parameter              INIT_FILE = "none",
  parameter int unsigned IDX_W     = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  addr_q;

  always_ff @(posedge clk) begin
    if (en) begin
      addr_q <= addr;
      if (we) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (byteenable[i]) begin
            mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
          end
        end
      end
    end
  end

  assign q = mem[addr_q];

endmodule

// File: rtl/onchip_memory_pipelined.sv
// Avalon-MM single-port on-chip RAM slave with optional zero-clear after
// reset and a 1- or 2-stage read pipeline.
//   clk, reset      : clock, asynchronous active-high reset
//   address         : word address (>= DEPTH: writes dropped, reads return 0)
//   byteenable      : per-byte write enable
//   chipselect      : slave select
//   read, write     : requests (write wins when both are set)
//   writedata       : write data
//   clken           : global clock enable
//   reset_req       : pending-reset request, stalls the RAM and pipeline
//   readdata        : read data, zero unless readdatavalid
//   readdatavalid   : one strobe per accepted read, READ_LATENCY cycles later
//   waitrequest     : request not accepted this cycle
//   init_done       : memory is accepting traffic
module onchip_memory_pipelined
  import onchip_mem_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 65536,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 0,
  parameter              INIT_FILE      = "none"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic                  clken,
  input  logic                  reset_req,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  output logic                  init_done
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam mem_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  mem_state_e          state, state_nxt;
  logic [IDX_W-1:0]    clr_cnt, clr_cnt_nxt;
  logic                clocken;
  logic                in_range;
  logic                accept;
  logic                rd_accept;
  logic                ram_en;
  logic                ram_we;
  logic [IDX_W-1:0]    ram_addr;
  logic [DATA_W/8-1:0] ram_be;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   q_ram;

  assign clocken  = clken & ~reset_req;
  assign in_range = ({1'b0, address} < DEPTH_LIM);
  // Reset is excluded from the RAM enable so nothing is written while reset is held.
  assign ram_en   = clocken & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    waitrequest = 1'b1;
    accept      = 1'b0;
    rd_accept   = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_be      = '0;
    ram_wdata   = '0;
    case (state)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
        ram_be   = '1;
        if (clocken) begin
          if (clr_cnt == IDX_W'(DEPTH - 1)) begin
            state_nxt = ST_RUN;
          end else begin
            clr_cnt_nxt = clr_cnt + 1'b1;
          end
        end
      end
      ST_RUN: begin
        waitrequest = ~clocken;
        accept      = chipselect & (read | write) & clocken;
        ram_we      = accept & write & in_range;
        // Out-of-range reads park the RAM on word 0; the data is masked later.
        ram_addr    = in_range ? address[IDX_W-1:0] : '0;
        ram_be      = byteenable;
        ram_wdata   = writedata;
        rd_accept   = accept & read & ~write;
      end
      default: begin
        state_nxt = RESET_STATE;
      end
    endcase
    if (reset) begin
      waitrequest = 1'b1;
    end
  end

  assign init_done = (state == ST_RUN) & ~reset;

  onchip_ram_core #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk        (clk),
    .en         (ram_en),
    .we         (ram_we),
    .addr       (ram_addr),
    .byteenable (ram_be),
    .wdata      (ram_wdata),
    .q          (q_ram)
  );

  // Latency pipe: every stage advances only on enabled cycles, so a stall
  // freezes both the valid bits and the registered RAM address.
  logic              vld1, oor1;
  logic              out_vld;
  logic [DATA_W-1:0] out_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld1 <= 1'b0;
      oor1 <= 1'b0;
    end else if (clocken) begin
      vld1 <= rd_accept;
      oor1 <= ~in_range;
    end
  end

  if (READ_LATENCY >= READ_LATENCY_MAX) begin : g_lat2
    logic              vld2;
    logic [DATA_W-1:0] data2;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld2  <= 1'b0;
        data2 <= '0;
      end else if (clocken) begin
        vld2  <= vld1;
        data2 <= oor1 ? '0 : q_ram;
      end
    end
    assign out_vld  = vld2;
    assign out_data = data2;
  end else begin : g_lat1
    assign out_vld  = vld1;
    assign out_data = oor1 ? '0 : q_ram;
  end

  // The strobe is suppressed on stalled cycles; the held beat is presented
  // on the next enabled cycle instead of being repeated.
  assign readdatavalid = out_vld & clocken;
  assign readdata      = readdatavalid ? out_data : '0;

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
module tb_onchip_memory_pipelined;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect, read, write, clken, reset_req;
  logic [31:0]   writedata;

  logic [31:0] rdata [2];
  logic        rdv   [2];
  logic        wreq  [2];
  logic        idone [2];

  always #5 clk = ~clk;

  onchip_memory_pipelined #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1), .INIT_FILE("none")
  ) u_lat1 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .readdata(rdata[0]),
    .readdatavalid(rdv[0]), .waitrequest(wreq[0]), .init_done(idone[0])
  );

  onchip_memory_pipelined #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1), .INIT_FILE("none")
  ) u_lat2 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .readdata(rdata[1]),
    .readdatavalid(rdv[1]), .waitrequest(wreq[1]), .init_done(idone[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: word array plus a list of accepted reads. A read accepted
  // in enabled cycle N is delivered in enabled cycle N+latency.
  typedef struct {
    logic [31:0] data;
    int unsigned idx;
  } rd_t;

  logic [31:0] mem_m [DEPTH];
  rd_t         rl[$];
  int unsigned nxt [2];
  int unsigned en_count;
  int unsigned lat_of [2] = '{1, 2};
  int unsigned scnt [2] = '{0, 0};
  logic [31:0] last_data [2];

  task automatic model_reset();
    rl.delete();
    nxt      = '{0, 0};
    en_count = 0;
  endtask

  // Entered and left at a falling edge; one call covers one rising edge.
  task automatic step(input logic cs, input logic rd, input logic wr,
                      input logic [AW-1:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic ck, input logic rq);
    logic        ce, exp_v;
    logic [31:0] exp_d;
    rd_t         item;
    chipselect = cs; read = rd; write = wr; address = a;
    byteenable = be; writedata = wd; clken = ck; reset_req = rq;
    #1;
    ce = ck & ~rq;
    if (ce) en_count++;
    for (int d = 0; d < 2; d++) begin
      exp_v = 1'b0;
      exp_d = '0;
      if (ce && nxt[d] < rl.size() && rl[nxt[d]].idx + lat_of[d] == en_count) begin
        exp_v = 1'b1;
        exp_d = rl[nxt[d]].data;
        nxt[d]++;
      end
      chk($sformatf("waitrequest lat%0d t=%0t", d + 1, $time), {31'b0, wreq[d]}, {31'b0, ~ce});
      chk($sformatf("readdatavalid lat%0d t=%0t", d + 1, $time), {31'b0, rdv[d]}, {31'b0, exp_v});
      if (exp_v) chk($sformatf("readdata lat%0d t=%0t", d + 1, $time), rdata[d], exp_d);
      if (rdv[d]) begin
        scnt[d]++;
        last_data[d] = rdata[d];
      end
    end
    if (cs && ce && rd && !wr) begin
      item.data = (a < DEPTH) ? mem_m[a[3:0]] : 32'h0;
      item.idx  = en_count;
      rl.push_back(item);
    end
    if (cs && ce && wr && a < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[a[3:0]][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1; reset_req = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset readdata lat%0d", d + 1), rdata[d], 32'h0);
      chk($sformatf("reset readdatavalid lat%0d", d + 1), {31'b0, rdv[d]}, 32'h0);
      chk($sformatf("reset waitrequest lat%0d", d + 1), {31'b0, wreq[d]}, 32'h1);
      chk($sformatf("reset init_done lat%0d", d + 1), {31'b0, idone[d]}, 32'h0);
    end
    @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  // Clear sweep after reset release; optional clken pause, optional abort
  // once abort_at enabled edges have happened (caller then asserts reset).
  task automatic clear_run(input int pause_at, input int pause_len, input int abort_at);
    int unsigned en_cnt;
    int unsigned cyc;
    logic        ck;
    en_cnt = 0;
    cyc    = 0;
    for (int c = 0; c < 60; c++) begin
      ck = !(c >= pause_at && c < pause_at + pause_len);
      chipselect = 1'b1; read = 1'b1; write = 1'b0; address = AW'(c % DEPTH);
      clken = ck; reset_req = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("clear waitrequest lat%0d c=%0d", d + 1, c), {31'b0, wreq[d]}, 32'h1);
        chk($sformatf("clear init_done lat%0d c=%0d", d + 1, c), {31'b0, idone[d]}, 32'h0);
        chk($sformatf("clear readdatavalid lat%0d c=%0d", d + 1, c), {31'b0, rdv[d]}, 32'h0);
      end
      if (ck) en_cnt++;
      cyc++;
      @(negedge clk);
      if (abort_at >= 0 && en_cnt == unsigned'(abort_at)) return;
      if (en_cnt == DEPTH) break;
    end
    chk("clear cycles", cyc, DEPTH + unsigned'(pause_len));
    chipselect = 1'b0; read = 1'b0; clken = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("post-clear init_done lat%0d", d + 1), {31'b0, idone[d]}, 32'h1);
      chk($sformatf("post-clear waitrequest lat%0d", d + 1), {31'b0, wreq[d]}, 32'h0);
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, AW'(i), '0, '0, 1'b1, 1'b0);
    idle(3);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   exp;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0 [2];
    int          j;
    logic        ck;

    tbl[0]  = '{1'b1, 5'd5,  4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b1, 5'd5,  4'h2, 32'h0000AA00, 32'h0};
    tbl[2]  = '{1'b0, 5'd5,  4'h0, 32'h0,        32'hDEADAAEF};
    tbl[3]  = '{1'b1, 5'd0,  4'hC, 32'hCAFE1234, 32'h0};
    tbl[4]  = '{1'b0, 5'd0,  4'h0, 32'h0,        32'hCAFE0000};
    tbl[5]  = '{1'b1, 5'd16, 4'hF, 32'h12345678, 32'h0};
    tbl[6]  = '{1'b0, 5'd16, 4'h0, 32'h0,        32'h00000000};
    tbl[7]  = '{1'b0, 5'd0,  4'h0, 32'h0,        32'hCAFE0000};
    tbl[8]  = '{1'b1, 5'd15, 4'h1, 32'h7777_77A5, 32'h0};
    tbl[9]  = '{1'b0, 5'd15, 4'h0, 32'h0,        32'h000000A5};
    tbl[10] = '{1'b1, 5'd0,  4'h0, 32'hFFFFFFFF, 32'h0};
    tbl[11] = '{1'b0, 5'd0,  4'h0, 32'h0,        32'hCAFE0000};
    tbl[12] = '{1'b1, 5'd31, 4'hF, 32'h55555555, 32'h0};
    tbl[13] = '{1'b0, 5'd31, 4'h0, 32'h0,        32'h00000000};

    reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0; clken = 1'b1; reset_req = 1'b0;
    model_reset();
    @(negedge clk);

    do_reset();
    clear_run(100, 0, -1);
    read_all();

    foreach (tbl[k]) begin
      s0 = scnt;
      step(1'b1, ~tbl[k].wr, tbl[k].wr, tbl[k].a, tbl[k].be, tbl[k].wd, 1'b1, 1'b0);
      idle(3);
      if (!tbl[k].wr) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("table[%0d] data lat%0d", k, d + 1), last_data[d], tbl[k].exp);
          chk($sformatf("table[%0d] strobes lat%0d", k, d + 1), scnt[d] - s0[d], 32'd1);
        end
      end
    end

    step(1'b1, 1'b0, 1'b1, 5'd3, 4'hF, 32'h11223344, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd3, 4'h0, 32'h0, 1'b1, 1'b0);
    idle(3);
    for (int d = 0; d < 2; d++) chk($sformatf("raw-next-cycle lat%0d", d + 1), last_data[d], 32'h11223344);

    s0 = scnt;
    step(1'b1, 1'b1, 1'b1, 5'd3, 4'hF, 32'h55667788, 1'b1, 1'b0);
    idle(3);
    for (int d = 0; d < 2; d++) chk($sformatf("rd+wr no strobe lat%0d", d + 1), scnt[d] - s0[d], 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'd3, 4'h0, 32'h0, 1'b1, 1'b0);
    idle(3);
    for (int d = 0; d < 2; d++) chk($sformatf("rd+wr write kept lat%0d", d + 1), last_data[d], 32'h55667788);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, AW'(i), 4'hF, 32'hA0000000 + i, 1'b1, 1'b0);
    s0 = scnt;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, AW'(i), '0, '0, 1'b1, 1'b0);
    idle(4);
    for (int d = 0; d < 2; d++) chk($sformatf("burst strobes lat%0d", d + 1), scnt[d] - s0[d], 32'd8);

    s0 = scnt;
    j = 0;
    for (int i = 0; i < 11; i++) begin
      ck = !(i >= 3 && i < 6);
      step(1'b1, 1'b1, 1'b0, AW'(j), '0, '0, ck, 1'b0);
      if (ck) j++;
    end
    idle(4);
    for (int d = 0; d < 2; d++) chk($sformatf("clken stall strobes lat%0d", d + 1), scnt[d] - s0[d], 32'd8);

    s0 = scnt;
    j = 0;
    for (int i = 0; i < 10; i++) begin
      ck = !(i == 4 || i == 5);
      step(1'b1, 1'b1, 1'b0, AW'(7 - j), '0, '0, 1'b1, ~ck);
      if (ck) j++;
    end
    idle(4);
    for (int d = 0; d < 2; d++) chk($sformatf("reset_req stall strobes lat%0d", d + 1), scnt[d] - s0[d], 32'd8);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom % 2, $urandom % 3 == 0,
           AW'($urandom_range(0, 20)), 4'($urandom), $urandom,
           ($urandom % 8) != 0, ($urandom % 10) == 0);
    end
    idle(4);

    s0 = scnt;
    step(1'b1, 1'b1, 1'b0, 5'd1, '0, '0, 1'b1, 1'b0);
    do_reset();
    for (int d = 0; d < 2; d++) chk($sformatf("reset flush strobes lat%0d", d + 1), scnt[d] - s0[d], 32'd0);
    clear_run(4, 3, -1);

    step(1'b1, 1'b0, 1'b1, 5'd9, 4'hF, 32'hFEEDF00D, 1'b1, 1'b0);
    do_reset();
    clear_run(100, 0, 7);
    do_reset();
    clear_run(100, 0, -1);
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
